ahb_lite_sram_responder: RTL

AHB_LITE_SRAM_RESPONDER -- requirements
Module: ahb_lite_sram_responder

---
 rtl/ahb_lite_sram_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_sram_responder.sv
// AHB-Lite SRAM responder: word-organised memory with byte-lane writes,
// programmable wait states and the two-cycle ERROR response.
module ahb_lite_sram_responder #(
  parameter int unsigned HADDR_SIZE  = 32,
  parameter int unsigned HDATA_SIZE  = 32,
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [HDATA_SIZE-1:0] HRDATA
);

  localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
  localparam int unsigned BYTE_AW = IDX_W + 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LANES   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  typedef struct packed {
    logic [BYTE_AW-1:0] addr;
    logic               write;
    logic [1:0]         size;
  } xfer_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  xfer_t                 xfer_q, xfer_new;
  logic                  accept;
  logic                  xfer_err;
  logic                  capture;
  logic                  ready_d;
  logic                  resp_d;
  logic [HDATA_SIZE-1:0] rdata_d;
  logic                  commit;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_is_write;
  logic [LANES-1:0]      be;
  logic [HDATA_SIZE-1:0] wr_word;
  logic [HDATA_SIZE-1:0] mem [MEM_WORDS];
  logic                  unused_ok;

  // Burst type, protection and the low HTRANS bit carry no meaning here.
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  assign accept = HSEL && HREADY && HTRANS[1];

  always_comb begin
    xfer_new       = '0;
    xfer_new.addr  = HADDR[BYTE_AW-1:0];
    xfer_new.write = HWRITE;
    xfer_new.size  = HSIZE[1:0];
  end

  assign xfer_err = ((HADDR >> BYTE_AW) != '0)
                 || (HSIZE > 3'b010)
                 || ((HSIZE == 3'b001) && HADDR[0])
                 || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

  // Next state and the registered response that goes with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    ready_d = 1'b1;
    resp_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          capture = 1'b1;
          if (xfer_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_WAIT: ready_d = 1'b0;
      ST_ERR1: begin
        ready_d = 1'b0;
        resp_d  = 1'b1;
      end
      ST_ERR2: resp_d = 1'b1;
      default: ;
    endcase
  end

  assign commit = (state_q == ST_DATA) && xfer_q.write;
  assign wr_idx = xfer_q.addr[BYTE_AW-1:2];

  always_comb begin
    be = '0;
    case (xfer_q.size)
      2'b00:   be[xfer_q.addr[1:0]] = 1'b1;
      2'b01:   be = xfer_q.addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    wr_word = mem[wr_idx];
    for (int i = 0; i < int'(LANES); i++) begin
      if (be[i]) begin
        wr_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // The read entering DATA sees a write committing on the same edge.
  assign rd_idx      = capture ? xfer_new.addr[BYTE_AW-1:2] : xfer_q.addr[BYTE_AW-1:2];
  assign rd_is_write = capture ? xfer_new.write : xfer_q.write;

  always_comb begin
    rdata_d = '0;
    if ((state_d == ST_DATA) && !rd_is_write) begin
      rdata_d = (commit && (rd_idx == wr_idx)) ? wr_word : mem[rd_idx];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      xfer_q    <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (capture) begin
        xfer_q <= xfer_new;
      end
      HREADYOUT <= ready_d;
      HRESP     <= resp_d;
      HRDATA    <= rdata_d;
    end
  end

  // Storage survives reset; a reset edge suppresses a pending commit.
  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) begin
      mem[wr_idx] <= wr_word;
    end
  end

endmodule
